// File: rtl/path_count_scheduler.sv
// path_count_scheduler
// Counts every distinct path from start_node to end_node in the DAG held by
// adjacency_map. It runs an iterative depth-first walk over an on-chip node
// stack. Each expanded node gets one query, and every destination returned is
// pushed. Each time end_node is popped the path counter is incremented.
//
// Optional build macro: PATH_COUNT_SATURATE_EN
//   defined   : path_count saturates at all-ones
//   undefined : path_count wraps modulo 2^COUNT_WIDTH
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   start                 pulse that begins a traversal (only from IDLE/DONE)
//   start_node, end_node  traversal endpoints, sampled on start
//   query_valid/ready     request towards adjacency_map
//   query_data            node whose edges are requested
//   reply_valid/ready     reply beats from adjacency_map
//   reply_data            destination node carried by a beat
//   reply_last            final beat of a reply
//   reply_no_edges_found  beat carries no destination
//   busy                  traversal in progress (POP/QUERY/RECEIVE)
//   done                  result valid, held until next start or reset
//   path_count            number of paths found
//   stack_overflow        sticky: a push was dropped on a full stack
//
// state   | meaning
// IDLE    | waiting for the first start
// POP     | pop one node per cycle; count end-node hits, else expand
// QUERY   | present cur_node to adjacency_map until accepted
// RECEIVE | push destinations from reply beats until reply_last
// DONE    | stack empty, result held
//
// STACK_DEPTH must be at least 2.
module path_count_scheduler #(
  parameter int MAX_NODES   = 1024,
  parameter int NODE_WIDTH  = $clog2(MAX_NODES),
  parameter int STACK_DEPTH = 512,
  parameter int COUNT_WIDTH = 48
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NODE_WIDTH-1:0]  start_node,
  input  logic [NODE_WIDTH-1:0]  end_node,
  input  logic                   query_ready,
  output logic                   query_valid,
  output logic [NODE_WIDTH-1:0]  query_data,
  input  logic                   reply_valid,
  input  logic [NODE_WIDTH-1:0]  reply_data,
  input  logic                   reply_last,
  input  logic                   reply_no_edges_found,
  output logic                   reply_ready,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] path_count,
  output logic                   stack_overflow
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_QUERY,
    S_RECEIVE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [NODE_WIDTH-1:0]  stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]        sp;
  logic [SP_W-1:0]        sp_m1;
  logic [NODE_WIDTH-1:0]  cur_node;
  logic [NODE_WIDTH-1:0]  end_q;
  logic [NODE_WIDTH-1:0]  top_node;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic                   start_ok;
  logic                   stack_empty;
  logic                   stack_full;
  logic                   pop_hit;
  logic                   push_req;

  assign start_ok    = start && (state_q == S_IDLE || state_q == S_DONE);
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign sp_m1       = sp - SP_W'(1);
  assign top_node    = stack_mem[sp_m1[IDX_W-1:0]];
  assign pop_hit     = (top_node == end_q);
  assign push_req    = (state_q == S_RECEIVE) && reply_valid && !reply_no_edges_found;
  assign query_data  = cur_node;

`ifdef PATH_COUNT_SATURATE_EN
  assign count_inc = (&path_count) ? path_count : path_count + COUNT_WIDTH'(1);
`else
  assign count_inc = path_count + COUNT_WIDTH'(1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    query_valid = 1'b0;
    reply_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_POP;
      end
      S_POP: begin
        busy = 1'b1;
        if (stack_empty)  state_d = S_DONE;
        else if (!pop_hit) state_d = S_QUERY;
      end
      S_QUERY: begin
        busy        = 1'b1;
        query_valid = 1'b1;
        if (query_ready) state_d = S_RECEIVE;
      end
      S_RECEIVE: begin
        busy        = 1'b1;
        reply_ready = 1'b1;
        if (reply_valid && reply_last) state_d = S_POP;
      end
      S_DONE: begin
        // done drops in the very cycle a restart is seen
        done = !start;
        if (start) state_d = S_POP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp             <= '0;
      cur_node       <= '0;
      end_q          <= '0;
      path_count     <= '0;
      stack_overflow <= 1'b0;
    end else begin
      if (start_ok) begin
        end_q          <= end_node;
        sp             <= SP_W'(1);
        path_count     <= '0;
        stack_overflow <= 1'b0;
      end else if (state_q == S_POP && !stack_empty) begin
        sp       <= sp_m1;
        cur_node <= top_node;
        if (pop_hit) path_count <= count_inc;
      end else if (push_req) begin
        // a full stack still consumes the beat; the result becomes a lower bound
        if (stack_full) stack_overflow <= 1'b1;
        else            sp <= sp + SP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_ok) begin
      stack_mem[0] <= start_node;
    end else if (push_req && !stack_full) begin
      stack_mem[sp[IDX_W-1:0]] <= reply_data;
    end
  end

endmodule

// File: tb/tb_path_count_scheduler.sv
module tb_path_count_scheduler;

  localparam int NW = 10;
  localparam int CW = 48;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_a, start_b;
  logic [NW-1:0] start_node, end_node;
  logic          query_ready;
  logic          reply_valid, reply_last, reply_nef;
  logic [NW-1:0] reply_data;

  logic          qv_a, rr_a, busy_a, done_a, ovf_a;
  logic [NW-1:0] qd_a;
  logic [CW-1:0] cnt_a;
  logic          qv_b, rr_b, busy_b, done_b, ovf_b;
  logic [NW-1:0] qd_b;
  logic [CW-1:0] cnt_b;

  logic          sel;
  logic          qv_s, rr_s, done_s;
  logic [NW-1:0] qd_s;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  path_count_scheduler dut (
    .clk(clk), .reset(reset), .start(start_a),
    .start_node(start_node), .end_node(end_node),
    .query_ready(query_ready), .query_valid(qv_a), .query_data(qd_a),
    .reply_valid(reply_valid), .reply_data(reply_data), .reply_last(reply_last),
    .reply_no_edges_found(reply_nef), .reply_ready(rr_a),
    .busy(busy_a), .done(done_a), .path_count(cnt_a), .stack_overflow(ovf_a)
  );

  path_count_scheduler #(.STACK_DEPTH(2)) dut_small (
    .clk(clk), .reset(reset), .start(start_b),
    .start_node(start_node), .end_node(end_node),
    .query_ready(query_ready), .query_valid(qv_b), .query_data(qd_b),
    .reply_valid(reply_valid), .reply_data(reply_data), .reply_last(reply_last),
    .reply_no_edges_found(reply_nef), .reply_ready(rr_b),
    .busy(busy_b), .done(done_b), .path_count(cnt_b), .stack_overflow(ovf_b)
  );

  assign qv_s   = sel ? qv_b   : qv_a;
  assign qd_s   = sel ? qd_b   : qd_a;
  assign rr_s   = sel ? rr_b   : rr_a;
  assign done_s = sel ? done_b : done_a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-written graph: you=1 a=2 b=3 c=4 out=9; node 10 fans out to 11,12,13
  function automatic int edges(input logic [NW-1:0] node, output logic [2:0][NW-1:0] d);
    d = '0;
    case (node)
      10'd1:  begin d[0] = 10'd2;  d[1] = 10'd3;  return 2; end
      10'd2:  begin d[0] = 10'd9;  return 1; end
      10'd3:  begin d[0] = 10'd9;  d[1] = 10'd4;  return 2; end
      10'd4:  begin d[0] = 10'd9;  return 1; end
      10'd10: begin d[0] = 10'd11; d[1] = 10'd12; d[2] = 10'd13; return 3; end
      default: return 0;
    endcase
  endfunction

  task automatic pulse_start(input logic s, input logic [NW-1:0] sn, input logic [NW-1:0] en);
    sel = s;
    @(negedge clk);
    start_node = sn;
    end_node   = en;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    #1 chk("done_low_on_start", done_s, 1'b0);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Answers queries from the selected DUT until done, budget expiry, or
  // (stop_at>0) until the stop_at-th query has been accepted.
  task automatic serve(input int hold, input int stop_at,
                       output int nq, output logic [7:0][NW-1:0] qlist,
                       output int unstable, output logic finished);
    int budget;
    int n;
    logic [NW-1:0] node;
    logic [2:0][NW-1:0] d;
    budget   = 0;
    nq       = 0;
    qlist    = '0;
    unstable = 0;
    finished = 1'b0;
    while (budget < 3000) begin
      if (done_s) begin finished = 1'b1; break; end
      if (qv_s) begin
        node = qd_s;
        if (nq < 8) qlist[nq] = node;
        nq++;
        budget++;
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          if (!(qv_s === 1'b1 && qd_s === node)) unstable++;
        end
        hold = 0;
        query_ready = 1'b1;
        @(negedge clk);
        if (stop_at > 0 && nq == stop_at) return;
        n = edges(node, d);
        if (n == 0) begin
          reply_valid = 1'b1; reply_nef = 1'b1; reply_last = 1'b1; reply_data = '0;
          @(negedge clk);
        end else begin
          for (int b = 0; b < n; b++) begin
            reply_valid = 1'b1; reply_nef = 1'b0;
            reply_data  = d[b];
            reply_last  = (b == n - 1);
            @(negedge clk);
          end
        end
        reply_valid = 1'b0; reply_nef = 1'b0; reply_last = 1'b0;
      end else begin
        @(negedge clk);
        budget++;
      end
    end
  endtask

  int                 nq, unstable;
  logic [7:0][NW-1:0] ql;
  logic               fin;

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    start_node = '0; end_node = '0; query_ready = 1'b1;
    reply_valid = 1'b0; reply_last = 1'b0; reply_nef = 1'b0; reply_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_query_valid", qv_a, 1'b0);
    chk("rst_reply_ready", rr_a, 1'b0);
    chk("rst_busy",        busy_a, 1'b0);
    chk("rst_done",        done_a, 1'b0);
    chk("rst_count",       cnt_a, 64'd0);
    chk("rst_overflow",    ovf_a, 1'b0);

    // 1: basic graph, 3 paths, queries you,b,c,a
    pulse_start(1'b0, 10'd1, 10'd9);
    chk("t1_busy", busy_a, 1'b1);
    serve(0, 0, nq, ql, unstable, fin);
    chk("t1_finished", fin, 1'b1);
    chk("t1_count", cnt_a, 64'd3);
    chk("t1_overflow", ovf_a, 1'b0);
    chk("t1_nq", nq, 64'd4);
    chk("t1_q0", ql[0], 64'd1);
    chk("t1_q1", ql[1], 64'd3);
    chk("t1_q2", ql[2], 64'd4);
    chk("t1_q3", ql[3], 64'd2);
    chk("t1_busy_done", busy_a, 1'b0);

    // 2: start == end, counted on first pop, done two cycles later
    pulse_start(1'b0, 10'd5, 10'd5);
    chk("t2_qv_c1", qv_a, 1'b0);
    chk("t2_done_c1", done_a, 1'b0);
    @(negedge clk);
    chk("t2_qv_c2", qv_a, 1'b0);
    chk("t2_done_c2", done_a, 1'b0);
    @(negedge clk);
    chk("t2_done_c3", done_a, 1'b1);
    chk("t2_count", cnt_a, 64'd1);

    // 3: start node without edges; a second start while busy is ignored
    pulse_start(1'b0, 10'd7, 10'd9);
    start_node = 10'd1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    serve(0, 0, nq, ql, unstable, fin);
    chk("t3_finished", fin, 1'b1);
    chk("t3_nq", nq, 64'd1);
    chk("t3_q0", ql[0], 64'd7);
    chk("t3_count", cnt_a, 64'd0);

    // 4: query_ready held low for 20 cycles
    query_ready = 1'b0;
    pulse_start(1'b0, 10'd1, 10'd9);
    serve(20, 0, nq, ql, unstable, fin);
    chk("t4_unstable", unstable, 64'd0);
    chk("t4_finished", fin, 1'b1);
    chk("t4_nq", nq, 64'd4);
    chk("t4_count", cnt_a, 64'd3);

    // 5: two-entry stack, fan-out of three overflows
    pulse_start(1'b1, 10'd10, 10'd11);
    serve(0, 0, nq, ql, unstable, fin);
    chk("t5_finished", fin, 1'b1);
    chk("t5_overflow", ovf_b, 1'b1);
    chk("t5_count", cnt_b, 64'd1);
    chk("t5_nq", nq, 64'd2);
    repeat (3) @(negedge clk);
    chk("t5_overflow_sticky", ovf_b, 1'b1);

    // 6: reset in RECEIVE of the fourth query (two paths already counted)
    pulse_start(1'b0, 10'd1, 10'd9);
    serve(0, 4, nq, ql, unstable, fin);
    chk("t6_pre_rr", rr_a, 1'b1);
    chk("t6_pre_count", cnt_a, 64'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_qv", qv_a, 1'b0);
    chk("t6_rr", rr_a, 1'b0);
    chk("t6_done", done_a, 1'b0);
    chk("t6_count", cnt_a, 64'd0);
    chk("t6_busy", busy_a, 1'b0);
    pulse_start(1'b0, 10'd1, 10'd9);
    serve(0, 0, nq, ql, unstable, fin);
    chk("t6_finished", fin, 1'b1);
    chk("t6_recount", cnt_a, 64'd3);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
